queue_writer: RTL

Write-side controller for the pathfinding node queue. Owns the write port of the 100-entry, 272-bit node memory and executes push, update, remove and clear commands from the search controller. Keeps the queue contiguous from address 0 so the existing minimum-node and child-lookup scanners, which stop at the first entry with node_id == 0, always see every live node. Tracks occupancy internally and clears the memory after every reset.

---
 rtl/queue_writer.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/queue_writer.sv
`default_nettype none
// ============================================================================
// Module   : queue_writer
// Purpose  : Write-side controller for the pathfinding node queue. Owns the
//            write port of the node memory and executes push / update /
//            remove / clear commands, keeping live nodes packed from address 0
//            so scanners that stop at the first node_id == 0 see every node.
//            The whole memory is zeroed after every reset.
// Ports    : clk, reset (sync, active-low)
//            cmd_valid/cmd_ready, cmd_op, cmd_addr, cmd_node  - command in
//            rd_address / rd_data                              - memory read
//            wr_enable / wr_address / wr_data                  - memory write
//            busy, done, error, count, full, result_address    - status
// Revision : 1.0 - initial release
// ============================================================================
module queue_writer #(
  parameter int MAX_NODES = 100
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  input  logic [1:0]   cmd_op,
  input  logic [6:0]   cmd_addr,
  input  logic [271:0] cmd_node,
  output logic         cmd_ready,
  output logic [6:0]   rd_address,
  input  logic [271:0] rd_data,
  output logic         wr_enable,
  output logic [6:0]   wr_address,
  output logic [271:0] wr_data,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [6:0]   count,
  output logic         full,
  output logic [6:0]   result_address
);

  localparam logic [6:0] c_max_nodes = 7'(MAX_NODES);
  localparam logic [1:0] c_op_push   = 2'b00;
  localparam logic [1:0] c_op_update = 2'b01;
  localparam logic [1:0] c_op_remove = 2'b10;
  localparam logic [1:0] c_op_clear  = 2'b11;

  typedef enum logic [3:0] {
    INIT_CLR = 4'd0,
    IDLE     = 4'd1,
    PUSH     = 4'd2,
    UPDATE   = 4'd3,
    RM_SET   = 4'd4,
    RM_WAIT  = 4'd5,
    RM_READ  = 4'd6,
    RM_MOVE  = 4'd7,
    RM_CLEAR = 4'd8,
    CLR      = 4'd9,
    DONE     = 4'd10
  } state_t;

  // The state register names the state whose outputs are currently visible;
  // every output is loaded on the edge that enters that state.
  state_t         state_q;
  logic [6:0]     clr_ptr_q;      // next address to zero in INIT_CLR / CLR
  logic [6:0]     addr_q;         // latched cmd_addr
  logic           cmd_ready_q;
  logic           busy_q;
  logic [6:0]     rd_address_q;
  logic           wr_enable_q;
  logic [6:0]     wr_address_q;
  logic [271:0]   wr_data_q;
  logic           done_q;
  logic           error_q;
  logic [6:0]     count_q;
  logic           full_q;
  logic [6:0]     result_address_q;

  logic [15:0]    w_node_id;
  logic [6:0]     w_last;

  assign w_node_id = cmd_node[239:224];
  assign w_last    = count_q - 7'd1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q          <= INIT_CLR;
      clr_ptr_q        <= '0;
      addr_q           <= '0;
      cmd_ready_q      <= 1'b0;
      busy_q           <= 1'b1;
      rd_address_q     <= '0;
      wr_enable_q      <= 1'b0;
      wr_address_q     <= '0;
      wr_data_q        <= '0;
      done_q           <= 1'b0;
      error_q          <= 1'b0;
      count_q          <= '0;
      full_q           <= 1'b0;
      result_address_q <= '0;
    end else begin
      // Single-cycle strobes fall unless a branch below reasserts them.
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      wr_enable_q <= 1'b0;

      case (state_q)
        INIT_CLR, CLR: begin
          if (clr_ptr_q == c_max_nodes) begin
            clr_ptr_q <= '0;
            if (state_q == INIT_CLR) begin
              state_q     <= IDLE;
              cmd_ready_q <= 1'b1;
              busy_q      <= 1'b0;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
              count_q <= '0;
              full_q  <= 1'b0;
            end
          end else begin
            wr_enable_q  <= 1'b1;
            wr_address_q <= clr_ptr_q;
            wr_data_q    <= '0;
            clr_ptr_q    <= clr_ptr_q + 7'd1;
          end
        end

        IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            addr_q      <= cmd_addr;
            // Rejection is decided here so a bad command goes straight to
            // DONE without ever touching the write port.
            state_q     <= DONE;
            done_q      <= 1'b1;
            error_q     <= 1'b1;
            case (cmd_op)
              c_op_push: begin
                if (!full_q && (w_node_id != 16'd0)) begin
                  state_q      <= PUSH;
                  done_q       <= 1'b0;
                  error_q      <= 1'b0;
                  wr_enable_q  <= 1'b1;
                  wr_address_q <= count_q;
                  wr_data_q    <= cmd_node;
                end
              end
              c_op_update: begin
                if ((cmd_addr < count_q) && (w_node_id != 16'd0)) begin
                  state_q      <= UPDATE;
                  done_q       <= 1'b0;
                  error_q      <= 1'b0;
                  wr_enable_q  <= 1'b1;
                  wr_address_q <= cmd_addr;
                  wr_data_q    <= cmd_node;
                end
              end
              c_op_remove: begin
                if (cmd_addr < count_q) begin
                  done_q  <= 1'b0;
                  error_q <= 1'b0;
                  if (cmd_addr == w_last) begin
                    state_q      <= RM_CLEAR;
                    wr_enable_q  <= 1'b1;
                    wr_address_q <= w_last;
                    wr_data_q    <= '0;
                  end else begin
                    // Fill the hole with the tail entry to stay contiguous.
                    state_q      <= RM_SET;
                    rd_address_q <= w_last;
                  end
                end
              end
              c_op_clear: begin
                state_q      <= CLR;
                done_q       <= 1'b0;
                error_q      <= 1'b0;
                wr_enable_q  <= 1'b1;
                wr_address_q <= '0;
                wr_data_q    <= '0;
                clr_ptr_q    <= 7'd1;
              end
              default: ;
            endcase
          end
        end

        PUSH: begin
          state_q          <= DONE;
          done_q           <= 1'b1;
          result_address_q <= count_q;
          count_q          <= count_q + 7'd1;
          full_q           <= ((count_q + 7'd1) == c_max_nodes);
        end

        UPDATE: begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end

        RM_SET:  state_q <= RM_WAIT;
        // Memory read latency is two edges after rd_address changes.
        RM_WAIT: state_q <= RM_READ;

        RM_READ: begin
          state_q      <= RM_MOVE;
          wr_enable_q  <= 1'b1;
          wr_address_q <= addr_q;
          wr_data_q    <= rd_data;
        end

        RM_MOVE: begin
          state_q      <= RM_CLEAR;
          wr_enable_q  <= 1'b1;
          wr_address_q <= w_last;
          wr_data_q    <= '0;
        end

        RM_CLEAR: begin
          state_q          <= DONE;
          done_q           <= 1'b1;
          count_q          <= w_last;
          full_q           <= 1'b0;
          result_address_q <= addr_q;
        end

        DONE: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end

        default: begin
          state_q     <= INIT_CLR;
          clr_ptr_q   <= '0;
          cmd_ready_q <= 1'b0;
          busy_q      <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign busy           = busy_q;
  assign rd_address     = rd_address_q;
  assign wr_enable      = wr_enable_q;
  assign wr_address     = wr_address_q;
  assign wr_data        = wr_data_q;
  assign done           = done_q;
  assign error          = error_q;
  assign count          = count_q;
  assign full           = full_q;
  assign result_address = result_address_q;

endmodule
`default_nettype wire
